mips_instr_loader: RTL and testbench
====================================

// Module: mips_instr_loader
// PURPOSE
//  Encodes instruction requests (R-format, LW, SW, BEQ) into 32-bit MIPS words.
//  Writes them, one per handshake, into consecutive word addresses of instruction memory.
//  This is the encode side of the opcode map the main control decoder consumes.
//  It sits between the testbench/boot host and the imem write port, and loads programs before the core runs.
// PARAMETERS
//  ADDR_W  32  imem byte-address width
//  CNT_W   9   width of num_instr/count (max 2^CNT_W-1 instructions per load)
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       reset, asynchronous, active-low
//  start       in   1       one-cycle pulse; latches base_addr and num_instr (IDLE only)
//  base_addr   in   ADDR_W  first byte address; bits[1:0] forced to 0
//  num_instr   in   CNT_W   number of instructions to load
//  req_valid   in   1       request present
//  req_ready   out  1       loader accepts request this cycle
//  req_kind    in   2       0=R, 1=LW, 2=SW, 3=BEQ
//  req_rs      in   5       rs field
//  req_rt      in   5       rt field
//  req_rd      in   5       rd field (R only)
//  req_funct   in   6       funct field (R only)
//  req_imm     in   16      immediate/offset (I-types only)
//  imem_we     out  1       write strobe, held until imem_ack
//  imem_addr   out  ADDR_W  write byte address
//  imem_wdata  out  32      encoded instruction
//  imem_ack    in   1       memory accepted write this cycle
//  busy        out  1       state != IDLE
//  done        out  1       one-cycle pulse at end of load
//  count       out  CNT_W   instructions written since last start
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; count=0; any in-flight write is dropped.
//  FSM:
//   IDLE:   req_ready=0. start -> latch base/num, count=0; num_instr==0 ? DONE : ACCEPT.
//   ACCEPT: req_ready=1. req_valid -> register encoded word + addr -> WRITE.
//   WRITE:  imem_we=1; addr/wdata stable; req_ready=0. imem_ack -> count++, addr+=4;
//           count+1==num ? DONE : ACCEPT.
//   DONE:   done=1 for exactly one cycle -> IDLE. count holds until next start.
//  start outside IDLE is ignored. req_valid outside ACCEPT is ignored and not consumed.
//  Latency: accept edge -> imem_we high next cycle. Peak throughput: 1 instr / 2 clk.
//  Encoding (shamt always 0):
//   R:   {6'b000000, rs, rt, rd, 5'b0, funct}
//   LW:  {6'b100011, rs, rt, imm}
//   SW:  {6'b101011, rs, rt, imm}
//   BEQ: {6'b000100, rs, rt, imm}
//  Unused fields (rd/funct for I-types, imm for R) are ignored.
//  Address arithmetic is modulo 2^ADDR_W; wrap is silent.
//  imem_ack while imem_we=0 is ignored.
//  rst_n low mid-WRITE: imem_we drops immediately (async); no retry after reset.
// STRUCTURE
//  Package mips_isa_pkg holds OP_RTYPE, OP_LW, OP_SW, OP_BEQ (6-bit) and the instr-kind enum.
//  The main control decoder imports the same package so opcodes stay single-sourced.
//  Sub-module mips_instr_encode: purely combinational kind+fields -> 32-bit word.
//  Loader = FSM + addr/count/wdata registers.
// TESTING
//  1 R rs=1 rt=2 rd=3 funct=0x20, base=0x100, num=1 -> write 0x00221820 @0x100; done pulse; count=1
//  2 LW rt=8 rs=29 imm=4, then SW same regs imm=8, base=0 -> 0x8FA80004 @0x0, 0xAFA80008 @0x4
//  3 BEQ rs=1 rt=2 imm=0xFFFF; imem_ack held low 3 clk -> we/addr/wdata stable, req_ready=0; 0x1022FFFF
//  4 num_instr=0 -> DONE next cycle, done 1 clk, no imem_we; start during busy ignored
//  5 ADDR_W=8, base=0xFD, num=2 -> writes @0xFC then @0x00 (align + wrap)
//  6 rst_n low in WRITE -> imem_we=0 same cycle, busy=0, count=0; next start loads cleanly

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Opcode constants and request-kind encoding shared by the loader and the main control decoder.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef enum logic [1:0] {
    KIND_R   = 2'd0,
    KIND_LW  = 2'd1,
    KIND_SW  = 2'd2,
    KIND_BEQ = 2'd3
  } instr_kind_e;

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational encoder: request kind plus register/immediate fields to a 32-bit MIPS word.
module mips_instr_encode
  import mips_isa_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (instr_kind_e'(kind))
      KIND_R:   word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      KIND_LW:  word = {OP_LW,  rs, rt, imm};
      KIND_SW:  word = {OP_SW,  rs, rt, imm};
      KIND_BEQ: word = {OP_BEQ, rs, rt, imm};
      default:  word = '0;
    endcase
  end

endmodule

// File: rtl/mips_instr_loader.sv
// Program loader: accepts encoded-instruction requests and writes them to consecutive imem words.
module mips_instr_loader
  import mips_isa_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_instr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [5:0]        req_funct,
  input  logic [15:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ack,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  num_lat;
  logic [31:0]       enc_word;

  mips_instr_encode u_encode (
    .kind  (req_kind),
    .rs    (req_rs),
    .rt    (req_rt),
    .rd    (req_rd),
    .funct (req_funct),
    .imm   (req_imm),
    .word  (enc_word)
  );

  // addr always holds the address of the next word to write; it doubles as imem_addr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr    <= '0;
      wdata   <= '0;
      cnt     <= '0;
      num_lat <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr    <= base_addr & ~{{(ADDR_W-2){1'b0}}, 2'b11};
            num_lat <= num_instr;
            cnt     <= '0;
            state   <= (num_instr == '0) ? S_DONE : S_ACCEPT;
          end
        end
        S_ACCEPT: begin
          if (req_valid) begin
            wdata <= enc_word;
            state <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (imem_ack) begin
            cnt   <= cnt + CNT_W'(1);
            addr  <= addr + ADDR_W'(4);
            state <= (cnt + CNT_W'(1) == num_lat) ? S_DONE : S_ACCEPT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == S_ACCEPT);
    imem_we    = (state == S_WRITE);
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    imem_addr  = addr;
    imem_wdata = wdata;
    count      = cnt;
  end

endmodule

// File: tb/tb_mips_instr_loader.sv
// Directed bench for mips_instr_loader: a 32-bit-address instance plus an 8-bit one for wrap checks.
module tb_mips_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [8:0]  num_instr;
  logic        req_valid;
  logic [1:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [5:0]  req_funct;
  logic [15:0] req_imm;
  logic        imem_ack;

  logic        req_ready, imem_we, busy, done;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  count;

  logic        req_ready8, imem_we8, busy8, done8;
  logic [7:0]  imem_addr8;
  logic [31:0] imem_wdata8;
  logic [8:0]  count8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_instr_loader #(.ADDR_W(32), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_instr(num_instr),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind), .req_rs(req_rs),
    .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct), .req_imm(req_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_ack(imem_ack),
    .busy(busy), .done(done), .count(count)
  );

  mips_instr_loader #(.ADDR_W(8), .CNT_W(9)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr[7:0]), .num_instr(num_instr),
    .req_valid(req_valid), .req_ready(req_ready8), .req_kind(req_kind), .req_rs(req_rs),
    .req_rt(req_rt), .req_rd(req_rd), .req_funct(req_funct), .req_imm(req_imm),
    .imem_we(imem_we8), .imem_addr(imem_addr8), .imem_wdata(imem_wdata8), .imem_ack(imem_ack),
    .busy(busy8), .done(done8), .count(count8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses start from IDLE; returns one cycle later with the loader in ACCEPT or DONE.
  task automatic do_start(input logic [31:0] base, input logic [8:0] num);
    base_addr = base;
    num_instr = num;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Presents one request in ACCEPT, acks the write one cycle later; reports what was on the bus.
  task automatic issue(input logic [1:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] funct, input logic [15:0] imm,
                       output logic we, output logic [31:0] addr, output logic [31:0] wdata,
                       output logic [7:0] addr8, output logic ready);
    req_kind = kind; req_rs = rs; req_rt = rt; req_rd = rd; req_funct = funct; req_imm = imm;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    we = imem_we; addr = imem_addr; wdata = imem_wdata; addr8 = imem_addr8; ready = req_ready;
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; base_addr = '0; num_instr = '0; req_valid = 0;
    req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_funct = '0; req_imm = '0;
    imem_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({imem_we, busy, done, req_ready, count, imem_addr, imem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b busy=%b done=%b ready=%b count=%0d addr=%h wdata=%h required all zero",
               imem_we, busy, done, req_ready, count, imem_addr, imem_wdata);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_rtype();
    logic we, rdy; logic [31:0] a, w; logic [7:0] a8;
    do_start(32'h100, 9'd1);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL r_ready: got %b required 1", req_ready); end
    issue(2'd0, 5'd1, 5'd2, 5'd3, 6'h20, 16'h1234, we, a, w, a8, rdy);
    checks++;
    if ({we, rdy, a, w} !== {1'b1, 1'b0, 32'h100, 32'h00221820}) begin
      errors++;
      $display("FAIL r_write: we=%b ready=%b addr=%h wdata=%h required we=1 ready=0 addr=00000100 wdata=00221820", we, rdy, a, w);
    end
    checks++;
    if ({done, count} !== {1'b1, 9'd1}) begin
      errors++; $display("FAIL r_done: done=%b count=%0d required done=1 count=1", done, count);
    end
    step();
    checks++;
    if ({done, busy, count} !== {1'b0, 1'b0, 9'd1}) begin
      errors++; $display("FAIL r_idle: done=%b busy=%b count=%0d required 0 0 1", done, busy, count);
    end
  endtask

  task automatic test_lw_sw();
    logic we, rdy; logic [31:0] a, w; logic [7:0] a8;
    do_start(32'h0, 9'd2);
    issue(2'd1, 5'd29, 5'd8, 5'd31, 6'h3F, 16'd4, we, a, w, a8, rdy);
    checks++;
    if ({we, a, w} !== {1'b1, 32'h0, 32'h8FA80004}) begin
      errors++; $display("FAIL lw_write: we=%b addr=%h wdata=%h required 1 00000000 8fa80004", we, a, w);
    end
    checks++;
    if ({done, req_ready, count} !== {1'b0, 1'b1, 9'd1}) begin
      errors++; $display("FAIL lw_mid: done=%b ready=%b count=%0d required 0 1 1", done, req_ready, count);
    end
    issue(2'd2, 5'd29, 5'd8, 5'd0, 6'h00, 16'd8, we, a, w, a8, rdy);
    checks++;
    if ({we, a, w} !== {1'b1, 32'h4, 32'hAFA80008}) begin
      errors++; $display("FAIL sw_write: we=%b addr=%h wdata=%h required 1 00000004 afa80008", we, a, w);
    end
    checks++;
    if ({done, count} !== {1'b1, 9'd2}) begin
      errors++; $display("FAIL sw_done: done=%b count=%0d required 1 2", done, count);
    end
    step();
  endtask

  task automatic test_beq_stall();
    do_start(32'h200, 9'd1);
    req_kind = 2'd3; req_rs = 5'd1; req_rt = 5'd2; req_imm = 16'hFFFF; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({imem_we, req_ready, imem_addr, imem_wdata} !== {1'b1, 1'b0, 32'h200, 32'h1022FFFF}) begin
        errors++;
        $display("FAIL beq_stall%0d: we=%b ready=%b addr=%h wdata=%h required 1 0 00000200 1022ffff",
                 i, imem_we, req_ready, imem_addr, imem_wdata);
      end
      step();
    end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({done, imem_we, count} !== {1'b1, 1'b0, 9'd1}) begin
      errors++; $display("FAIL beq_done: done=%b we=%b count=%0d required 1 0 1", done, imem_we, count);
    end
    step();
  endtask

  task automatic test_zero_and_ignore();
    logic we, rdy; logic [31:0] a, w; logic [7:0] a8;
    do_start(32'h300, 9'd0);
    checks++;
    if ({done, busy, imem_we, count} !== {1'b1, 1'b1, 1'b0, 9'd0}) begin
      errors++; $display("FAIL zero_done: done=%b busy=%b we=%b count=%0d required 1 1 0 0", done, busy, imem_we, count);
    end
    step();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++; $display("FAIL zero_idle: done=%b busy=%b required 0 0", done, busy);
    end
    do_start(32'h300, 9'd2);
    // A stray start in ACCEPT must not relatch base/num.
    base_addr = 32'h400; num_instr = 9'd1; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ignore_ready: got %b required 1", req_ready); end
    issue(2'd0, 5'd4, 5'd5, 5'd6, 6'h22, 16'h0, we, a, w, a8, rdy);
    checks++;
    if ({a, w, done} !== {32'h300, 32'h00853022, 1'b0}) begin
      errors++; $display("FAIL ignore_first: addr=%h wdata=%h done=%b required 00000300 00853022 0", a, w, done);
    end
    issue(2'd3, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0010, we, a, w, a8, rdy);
    checks++;
    if ({a, w, done, count} !== {32'h304, 32'h10000010, 1'b1, 9'd2}) begin
      errors++; $display("FAIL ignore_second: addr=%h wdata=%h done=%b count=%0d required 00000304 10000010 1 2", a, w, done, count);
    end
    step();
  endtask

  task automatic test_wrap8();
    logic we, rdy; logic [31:0] a, w; logic [7:0] a8;
    do_start(32'hFD, 9'd2);
    issue(2'd1, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0001, we, a, w, a8, rdy);
    checks++;
    if (a8 !== 8'hFC) begin errors++; $display("FAIL wrap_first: addr8=%h required fc", a8); end
    issue(2'd2, 5'd2, 5'd3, 5'd0, 6'h0, 16'h0002, we, a, w, a8, rdy);
    checks++;
    if ({a8, imem_wdata8, done8, count8} !== {8'h00, 32'hAC430002, 1'b1, 9'd2}) begin
      errors++; $display("FAIL wrap_second: addr8=%h wdata8=%h done8=%b count8=%0d required 00 ac430002 1 2",
                         a8, imem_wdata8, done8, count8);
    end
    step();
  endtask

  task automatic test_reset_mid_write();
    logic we, rdy; logic [31:0] a, w; logic [7:0] a8;
    do_start(32'h500, 9'd2);
    issue(2'd0, 5'd1, 5'd1, 5'd1, 6'h20, 16'h0, we, a, w, a8, rdy);
    req_kind = 2'd1; req_rs = 5'd9; req_rt = 5'd10; req_imm = 16'h0020; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if ({imem_we, count} !== {1'b1, 9'd1}) begin
      errors++; $display("FAIL rst_pre: we=%b count=%0d required 1 1", imem_we, count);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_we, busy, count, done} !== {1'b0, 1'b0, 9'd0, 1'b0}) begin
      errors++; $display("FAIL rst_async: we=%b busy=%b count=%0d done=%b required 0 0 0 0", imem_we, busy, count, done);
    end
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    checks++;
    if ({imem_we, busy} !== 2'b00) begin
      errors++; $display("FAIL rst_held: we=%b busy=%b required 0 0", imem_we, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
    do_start(32'h600, 9'd1);
    issue(2'd1, 5'd9, 5'd10, 5'd0, 6'h0, 16'h0020, we, a, w, a8, rdy);
    checks++;
    if ({we, a, w, done, count} !== {1'b1, 32'h600, 32'h8D2A0020, 1'b1, 9'd1}) begin
      errors++; $display("FAIL rst_reload: we=%b addr=%h wdata=%h done=%b count=%0d required 1 00000600 8d2a0020 1 1",
                         we, a, w, done, count);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_sw();
    test_beq_stall();
    test_zero_and_ignore();
    test_wrap8();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
